neural_output_layer: RTL and testbench

//  Output (second) layer of the 2-2-1 XOR network. Consumes the two signed
//  Q4.4 activations from the hidden layer when that layer raises its layer

---
 rtl/neural_output_layer.sv | 169 ++++++++++++++++
 tb/tb_neural_output_layer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/neural_output_layer.sv
// Output neuron of the 2-2-1 XOR network: two-step MAC, bias, saturation,
// hard-sigmoid, with a 4-phase req/ack handshake toward the hidden layer.
module neural_output_layer #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    parameter int ACC_W = 16,
    parameter int W0    = 32,
    parameter int W1    = -32,
    parameter int BIAS  = -8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic signed [WIDTH-1:0] a0,
    input  logic signed [WIDTH-1:0] a1,
    output logic                    ack,
    output logic                    busy,
    output logic signed [WIDTH-1:0] z,
    output logic        [WIDTH-1:0] y,
    output logic                    cls
);

    localparam int ACT_W = WIDTH + 2;

    localparam logic signed [WIDTH-1:0] W0_C     = WIDTH'(W0);
    localparam logic signed [WIDTH-1:0] W1_C     = WIDTH'(W1);
    localparam logic signed [ACC_W-1:0] BIAS_C   = ACC_W'(BIAS);
    localparam logic signed [ACC_W-1:0] ZMAX_C   = ACC_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ZMIN_C   = ACC_W'(-(2 ** (WIDTH - 1)));
    localparam logic signed [ACT_W-1:0] HALF_ACT = ACT_W'(8);
    localparam logic signed [ACT_W-1:0] ONE_ACT  = ACT_W'(16);
    localparam logic        [WIDTH-1:0] HALF_Y   = WIDTH'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_ACT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      req_q;
    logic                      load;
    logic signed [WIDTH-1:0]   a0_q, a1_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      idx_q, idx_d;
    logic                      ack_q, ack_d;
    logic                      busy_q, busy_d;
    logic signed [WIDTH-1:0]   z_q, z_d;
    logic        [WIDTH-1:0]   y_q, y_d;
    logic                      cls_q, cls_d;

    logic signed [WIDTH-1:0]   a_sel, w_sel, z_shr;
    logic signed [2*WIDTH-1:0] prod, prod_sh;
    logic signed [ACC_W-1:0]   acc_bias;
    logic signed [ACT_W-1:0]   act_pre;
    logic        [WIDTH-1:0]   y_new;

    always_comb begin
        a_sel    = idx_q ? a1_q : a0_q;
        w_sel    = idx_q ? W1_C : W0_C;
        prod     = a_sel * w_sel;
        prod_sh  = prod >>> FRAC;
        acc_bias = acc_q + BIAS_C;
        // Hard-sigmoid slope 1/4 centred on 0.5, clamped to [0.0, 1.0]
        z_shr    = z_q >>> 2;
        act_pre  = ACT_W'(z_shr) + HALF_ACT;
        if (act_pre[ACT_W-1]) begin
            y_new = '0;
        end else if (act_pre > ONE_ACT) begin
            y_new = WIDTH'(ONE_ACT);
        end else begin
            y_new = WIDTH'(act_pre);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        acc_d   = acc_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        z_d     = z_q;
        y_d     = y_q;
        cls_d   = cls_q;
        case (state_q)
            S_IDLE: begin
                if (req && !req_q) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    idx_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod_sh);
                idx_d = 1'b1;
                if (idx_q) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                acc_d = acc_bias;
                if (acc_bias > ZMAX_C) begin
                    z_d = WIDTH'(ZMAX_C);
                end else if (acc_bias < ZMIN_C) begin
                    z_d = WIDTH'(ZMIN_C);
                end else begin
                    z_d = WIDTH'(acc_bias);
                end
                state_d = S_ACT;
            end
            S_ACT: begin
                y_d     = y_new;
                cls_d   = (y_new >= HALF_Y);
                ack_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            acc_q   <= '0;
            idx_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            z_q     <= '0;
            y_q     <= '0;
            cls_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req;
            if (load) begin
                a0_q <= a0;
                a1_q <= a1;
            end
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            z_q     <= z_d;
            y_q     <= y_d;
            cls_q   <= cls_d;
        end
    end

    assign ack  = ack_q;
    assign busy = busy_q;
    assign z    = z_q;
    assign y    = y_q;
    assign cls  = cls_q;

endmodule

// File: tb/tb_neural_output_layer.sv
// Directed bench for neural_output_layer: default neuron plus two bias
// variants sharing one handshake, with hand-computed expected outputs.
module tb_neural_output_layer;

    logic              clk;
    logic              rst;
    logic              req;
    logic signed [7:0] a0, a1;

    logic              ack0, busy0, cls0;
    logic signed [7:0] z0;
    logic        [7:0] y0;
    logic              ack1, busy1, cls1;
    logic signed [7:0] z1;
    logic        [7:0] y1;
    logic              ack2, busy2, cls2;
    logic signed [7:0] z2;
    logic        [7:0] y2;

    int n_checks;
    int n_fail;

    neural_output_layer u_dut (
        .clk(clk), .rst(rst), .req(req), .a0(a0), .a1(a1),
        .ack(ack0), .busy(busy0), .z(z0), .y(y0), .cls(cls0)
    );

    neural_output_layer #(.BIAS(0)) u_bias0 (
        .clk(clk), .rst(rst), .req(req), .a0(a0), .a1(a1),
        .ack(ack1), .busy(busy1), .z(z1), .y(y1), .cls(cls1)
    );

    neural_output_layer #(.BIAS(-1)) u_biasm1 (
        .clk(clk), .rst(rst), .req(req), .a0(a0), .a1(a1),
        .ack(ack2), .busy(busy2), .z(z2), .y(y2), .cls(cls2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises req and follows the transaction up to ack; req is left high.
    task automatic do_txn(input string tag, input int ia0, input int ia1,
                          input int ez, input int ey, input int ecls);
        a0  = 8'(ia0);
        a1  = 8'(ia1);
        req = 1'b1;
        step();
        check({tag, " busy@accept"}, int'(busy0), 1);
        check({tag, " ack@accept"}, int'(ack0), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("%s ack@edge%0d", tag, i), int'(ack0), 0);
        end
        step();
        check({tag, " ack@edge4"}, int'(ack0), 1);
        check({tag, " z"}, int'(z0), ez);
        check({tag, " y"}, int'(y0), ey);
        check({tag, " cls"}, int'(cls0), ecls);
    endtask

    task automatic release_req(input string tag);
        req = 1'b0;
        step();
        check({tag, " ack@release"}, int'(ack0), 0);
        check({tag, " busy@release"}, int'(busy0), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        req = 1'b0;
        a0  = '0;
        a1  = '0;
        #1;
        check("rst ack", int'(ack0), 0);
        check("rst busy", int'(busy0), 0);
        check("rst z", int'(z0), 0);
        check("rst y", int'(y0), 0);
        check("rst cls", int'(cls0), 0);
        step();
        step();
        rst = 1'b1;
        step();

        do_txn("c1", 16, 0, 24, 14, 1);
        release_req("c1");

        do_txn("c2", 0, 16, -40, 0, 0);
        release_req("c2");

        do_txn("c3", 127, -128, 127, 16, 1);
        release_req("c3");

        do_txn("c4", 0, 0, -8, 6, 0);
        check("c4 bias0 z", int'(z1), 0);
        check("c4 bias0 y", int'(y1), 8);
        check("c4 bias0 cls", int'(cls1), 1);
        check("c4 biasm1 z", int'(z2), -1);
        check("c4 biasm1 y", int'(y2), 7);
        check("c4 biasm1 cls", int'(cls2), 0);
        release_req("c4");

        do_txn("c5", 16, 0, 24, 14, 1);
        for (int i = 0; i < 10; i++) begin
            a0 = 8'(i * 13 - 60);
            a1 = 8'(50 - i * 7);
            step();
            check("c5 hold ack", int'(ack0), 1);
            check("c5 hold busy", int'(busy0), 1);
            check("c5 hold z", int'(z0), 24);
            check("c5 hold y", int'(y0), 14);
            check("c5 hold cls", int'(cls0), 1);
        end
        release_req("c5");
        do_txn("c5 reaccept", 0, 16, -40, 0, 0);
        release_req("c5 reaccept");

        // Leave a nonzero result behind so the reset clear is observable
        do_txn("c6 pre", 16, 0, 24, 14, 1);
        release_req("c6 pre");
        a0  = 8'(16);
        a1  = 8'(0);
        req = 1'b1;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("c6 rst ack", int'(ack0), 0);
        check("c6 rst busy", int'(busy0), 0);
        check("c6 rst z", int'(z0), 0);
        check("c6 rst y", int'(y0), 0);
        check("c6 rst cls", int'(cls0), 0);
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("c6 no ack in rst", int'(ack0), 0);
        end
        rst = 1'b1;
        step();
        check("c6 idle after rst", int'(busy0), 0);
        do_txn("c6 post", 16, 0, 24, 14, 1);
        release_req("c6 post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
